cic_rate_ctrl: RTL
==================

CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameter RATE_DW, default 32: width of the rate word.
REQ-002 SHALL have parameter CIC_R_MAX, default 10: maximum legal decimation ratio; also the reset rate.
REQ-003 SHALL have parameter FLUSH_OUT, default 7 (= CIC_N): number of filter outputs suppressed after reset or a rate change.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port s_axis_cfg_tdata, input, RATE_DW: requested decimation ratio, unsigned.
REQ-007 SHALL have port s_axis_cfg_tvalid, input, 1: rate request valid.
REQ-008 SHALL have port s_axis_cfg_tready, output, 1: request accepted when tvalid&tready.
REQ-009 SHALL have port cic_in_tvalid, input, 1: copy of the filter input sample strobe.
REQ-010 SHALL have port cic_out_tvalid, input, 1: filter output valid.
REQ-011 SHALL have port m_axis_rate_tdata, output, RATE_DW: rate to the filter rate port.
REQ-012 SHALL have port m_axis_rate_tvalid, output, 1: one-cycle rate load strobe to the filter.
REQ-013 SHALL have port out_tvalid_gated, output, 1: cic_out_tvalid & out_gate (combinational).
REQ-014 SHALL have port current_rate, output, RATE_DW: rate currently applied.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port cfg_error, output, 1: one-cycle pulse on rejected request.

Function
REQ-017 SHALL implement states IDLE, WAIT_BND, APPLY, FLUSH; busy = (state != IDLE).
REQ-018 SHALL assert s_axis_cfg_tready only in IDLE; requests in other states stall (tvalid held by source).
REQ-019 IDLE, handshake with 1 <= tdata <= CIC_R_MAX: latch pending rate, go WAIT_BND next cycle.
REQ-020 IDLE, handshake with tdata == 0 or > CIC_R_MAX: pulse cfg_error 1 cycle, stay IDLE, current_rate unchanged.
REQ-021 SHALL keep phase counter (RATE_DW bits): increments on each cic_in_tvalid, wraps to 0 when value == current_rate-1; current_rate == 1 keeps it 0.
REQ-022 WAIT_BND: boundary = cic_in_tvalid with phase == current_rate-1; on boundary go APPLY next cycle; no timeout.
REQ-023 APPLY (exactly 1 cycle): m_axis_rate_tvalid=1, m_axis_rate_tdata=pending; current_rate<=pending; phase<=0, or 1 if cic_in_tvalid in the same cycle; flush count<=0; next FLUSH.
REQ-024 m_axis_rate_tdata SHALL hold current_rate outside APPLY; m_axis_rate_tvalid 0 outside APPLY.
REQ-025 FLUSH: out_gate=0; count cic_out_tvalid pulses; on the pulse making count == FLUSH_OUT go IDLE next cycle (that pulse still gated); FLUSH_OUT == 0 goes straight to IDLE.
REQ-026 out_gate SHALL be 1 in IDLE, WAIT_BND and APPLY; 0 in FLUSH.
REQ-027 Request for the same rate as current_rate SHALL follow the full WAIT_BND/APPLY/FLUSH sequence (no short-cut).
REQ-028 Flush counter SHALL saturate at FLUSH_OUT; width clog2(FLUSH_OUT+1), min 1.

Reset
REQ-029 On reset_n low (any state, mid-sequence included): state=FLUSH, flush count=0, phase=0, current_rate=CIC_R_MAX, pending discarded; outputs: tready=0, m_axis_rate_tvalid=0, m_axis_rate_tdata=CIC_R_MAX, cfg_error=0, busy=1, out_gate=0.
REQ-030 After reset release the first FLUSH_OUT cic_out_tvalid pulses SHALL be suppressed before IDLE.

Verification
REQ-031 Reset release, 7 cic_out_tvalid pulses -> out_tvalid_gated stays 0, busy falls cycle after 7th, tready=1 next.
REQ-032 IDLE, rate 4 requested, phase=3 mid-stream -> APPLY on cycle after next cic_in_tvalid with phase==9; m_axis_rate_tvalid one cycle with tdata=4; current_rate=4.
REQ-033 Request tdata=0 then tdata=11 -> two cfg_error pulses, current_rate stays 10, busy stays 0.
REQ-034 Second request held valid during FLUSH -> tready=0 until IDLE, then accepted first IDLE cycle.
REQ-035 reset_n pulsed low during WAIT_BND with pending=3 -> current_rate=10, no m_axis_rate_tvalid, flush of 7 outputs repeats.
REQ-036 Rate 1 request -> APPLY on next cic_in_tvalid after boundary; subsequent phase stays 0; flush still gates 7 outputs.

Source files
------------

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl
//   Run-time decimation-ratio controller for a CIC decimator. Accepts a
//   requested ratio on an AXI-stream style config port, validates it, waits
//   for the next decimation-frame boundary of the input sample stream, loads
//   the new ratio into the filter with a one-cycle strobe, then suppresses
//   the first FLUSH_OUT filter outputs while the integrator/comb pipeline
//   settles. Reset behaves like a rate change to CIC_R_MAX, so it also flushes.
//
// Ports
//   clk, reset_n         : clock (rising edge), async active-low reset
//   s_axis_cfg_t*        : requested ratio (tdata), valid, ready
//   cic_in_tvalid        : copy of the filter input sample strobe
//   cic_out_tvalid       : filter output valid
//   m_axis_rate_t*       : rate word and one-cycle load strobe to the filter
//   out_tvalid_gated     : cic_out_tvalid masked while flushing
//   current_rate         : ratio currently applied
//   busy                 : controller is not idle
//   cfg_error            : one-cycle pulse when a request is rejected
module cic_rate_ctrl #(
  parameter int unsigned RATE_DW   = 32,
  parameter int unsigned CIC_R_MAX = 10,
  parameter int unsigned FLUSH_OUT = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
  input  logic               s_axis_cfg_tvalid,
  output logic               s_axis_cfg_tready,
  input  logic               cic_in_tvalid,
  input  logic               cic_out_tvalid,
  output logic [RATE_DW-1:0] m_axis_rate_tdata,
  output logic               m_axis_rate_tvalid,
  output logic               out_tvalid_gated,
  output logic [RATE_DW-1:0] current_rate,
  output logic               busy,
  output logic               cfg_error
);

  localparam int unsigned FCW = (FLUSH_OUT == 0) ? 1 : $clog2(FLUSH_OUT + 1);
  localparam logic [RATE_DW-1:0] R_MAX = RATE_DW'(CIC_R_MAX);
  localparam logic [RATE_DW-1:0] ONE   = RATE_DW'(1);
  localparam logic [FCW-1:0]     F_MAX = FCW'(FLUSH_OUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BND,
    APPLY,
    FLUSH
  } state_t;

  state_t             state;
  logic [RATE_DW-1:0] pending;
  logic [RATE_DW-1:0] phase;
  logic [FCW-1:0]     flush_cnt;

  logic cfg_hs;
  logic cfg_ok;
  logic at_bnd;

  assign cfg_hs = s_axis_cfg_tvalid && s_axis_cfg_tready;
  assign cfg_ok = (s_axis_cfg_tdata != '0) && (s_axis_cfg_tdata <= R_MAX);
  // Last sample of the current decimation frame.
  assign at_bnd = (phase == (current_rate - ONE));

  // All outputs decode directly from registered state.
  assign s_axis_cfg_tready  = (state == IDLE);
  assign busy               = (state != IDLE);
  assign m_axis_rate_tvalid = (state == APPLY);
  assign m_axis_rate_tdata  = (state == APPLY) ? pending : current_rate;
  assign out_tvalid_gated   = cic_out_tvalid && (state != FLUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FLUSH;
      pending      <= '0;
      phase        <= '0;
      current_rate <= R_MAX;
      flush_cnt    <= '0;
      cfg_error    <= 1'b0;
    end else begin
      cfg_error <= 1'b0;

      // Frame phase tracks the input stream; APPLY restarts the frame, and a
      // sample arriving in that very cycle is the first of the new frame
      // (unless the new ratio is 1, where every sample closes a frame).
      if (state == APPLY) begin
        phase <= (cic_in_tvalid && (pending != ONE)) ? ONE : '0;
      end else if (cic_in_tvalid) begin
        phase <= at_bnd ? '0 : (phase + ONE);
      end

      case (state)
        IDLE: begin
          if (cfg_hs) begin
            if (cfg_ok) begin
              pending <= s_axis_cfg_tdata;
              state   <= WAIT_BND;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        WAIT_BND: begin
          if (cic_in_tvalid && at_bnd) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          current_rate <= pending;
          flush_cnt    <= '0;
          state        <= FLUSH;
        end
        FLUSH: begin
          if (F_MAX == '0) begin
            state <= IDLE;
          end else if (cic_out_tvalid) begin
            if (flush_cnt != F_MAX) begin
              flush_cnt <= flush_cnt + FCW'(1);
            end
            if (flush_cnt == (F_MAX - FCW'(1))) begin
              state <= IDLE;
            end
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule
